// File: rtl/sequenciador_alarme_temperatura_pkg.sv
// Shared definitions for the temperature-alarm sequencer.
// Holds the sensor count, the scan-order index constants, the default
// per-sensor limits (degrees C), and the controller state encoding.
package pacote_temperatura;

  localparam int unsigned NUM_SENSORES = 7;

  // Fixed scan order of the sensors
  localparam logic [2:0] IDX_SC    = 3'd0;
  localparam logic [2:0] IDX_S1    = 3'd1;
  localparam logic [2:0] IDX_S2    = 3'd2;
  localparam logic [2:0] IDX_S3    = 3'd3;
  localparam logic [2:0] IDX_TUBSR = 3'd4;
  localparam logic [2:0] IDX_TUBSS = 3'd5;
  localparam logic [2:0] IDX_REA   = 3'd6;

  // Default limits, degrees C
  localparam int unsigned LIMIAR_SC_PADRAO    = 50;
  localparam int unsigned LIMIAR_GERAL_PADRAO = 100;
  localparam int unsigned LIMIAR_REA_PADRAO   = 300;

  typedef enum logic [1:0] {
    OCIOSO,
    VARRE,
    ALARME
  } estado_t;

endpackage

// File: rtl/sequenciador_alarme_temperatura_if.sv
// Bus between the sensor side / control-room annunciator and the
// temperature-alarm sequencer.
//   habilita, reconhece          : scan enable, operator acknowledge
//   sensTemp{SC,S1,S2,S3,TubSR,TubSS} : 8-bit temperatures, unsigned C
//   sensTempRea                  : 9-bit reactor temperature, unsigned C
//   alarmeSonoroTemperatura      : latched audible alarm
//   origemAlarme                 : index of the sensor that caused the latch
//   mascaraExcedido              : per-sensor "counter at persistence limit"
//   varreduraCompleta            : one-cycle pulse at end of each full scan
// master = sensor/annunciator side, slave = sequencer.
interface sequenciador_alarme_temperatura_if;

  logic       habilita;
  logic       reconhece;
  logic [7:0] sensTempSC;
  logic [7:0] sensTempS1;
  logic [7:0] sensTempS2;
  logic [7:0] sensTempS3;
  logic [7:0] sensTempTubSR;
  logic [7:0] sensTempTubSS;
  logic [8:0] sensTempRea;
  logic       alarmeSonoroTemperatura;
  logic [2:0] origemAlarme;
  logic [6:0] mascaraExcedido;
  logic       varreduraCompleta;

  modport master (
    output habilita, reconhece,
    output sensTempSC, sensTempS1, sensTempS2, sensTempS3,
    output sensTempTubSR, sensTempTubSS, sensTempRea,
    input  alarmeSonoroTemperatura, origemAlarme, mascaraExcedido,
    input  varreduraCompleta
  );

  modport slave (
    input  habilita, reconhece,
    input  sensTempSC, sensTempS1, sensTempS2, sensTempS3,
    input  sensTempTubSR, sensTempTubSS, sensTempRea,
    output alarmeSonoroTemperatura, origemAlarme, mascaraExcedido,
    output varreduraCompleta
  );

endinterface

// File: rtl/sequenciador_alarme_temperatura_contador_persistencia.sv
// Persistence counter for one sensor.
//   clk, rst : clock, asynchronous active-high reset
//   limpa    : synchronous clear (wins over everything else)
//   enable   : this sensor is being sampled on this edge
//   exceed   : sampled value is at/over its limit
//   atingido : registered flag, counter has reached PERSIST
//   disparo  : combinational, counter reaches PERSIST on this edge
module contador_persistencia #(
  parameter int unsigned PERSIST = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic limpa,
  input  logic enable,
  input  logic exceed,
  output logic atingido,
  output logic disparo
);

  localparam int unsigned CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] MAXV = CW'(PERSIST);

  logic [CW-1:0] cont;

  // Trip only on the transition into PERSIST; a saturated counter does not re-trip
  assign disparo = enable && exceed && (cont == MAXV - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont     <= '0;
      atingido <= 1'b0;
    end else if (limpa) begin
      cont     <= '0;
      atingido <= 1'b0;
    end else if (enable) begin
      if (exceed) begin
        if (cont != MAXV) cont <= cont + CW'(1);
        atingido <= (cont >= MAXV - CW'(1));
      end else begin
        cont     <= '0;
        atingido <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sequenciador_alarme_temperatura.sv
// Temperature-alarm sequencer: scans seven sensors round-robin through one
// shared >= comparator, requires PERSIST consecutive over-limit samples of a
// sensor to trip, and latches the audible alarm until an acknowledge arrives
// with every sensor back below persistence.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of sequenciador_alarme_temperatura_if
// Parameters: PERSIST (1..7), LIMIAR_SC, LIMIAR_GERAL, LIMIAR_REA (C).
module sequenciador_alarme_temperatura
  import pacote_temperatura::*;
#(
  parameter int unsigned PERSIST      = 3,
  parameter int unsigned LIMIAR_SC    = LIMIAR_SC_PADRAO,
  parameter int unsigned LIMIAR_GERAL = LIMIAR_GERAL_PADRAO,
  parameter int unsigned LIMIAR_REA   = LIMIAR_REA_PADRAO
) (
  input logic clk,
  input logic rst,
  sequenciador_alarme_temperatura_if.slave bus
);

  estado_t estadoAtual, proxEstado;
  logic [2:0] idx, proxIdx, idxSeguinte;

  logic       alarme, proxAlarme;
  logic [2:0] origem, proxOrigem;
  logic       varredura, proxVarredura;

  logic [8:0] amostra;
  logic [8:0] limiar;
  logic       excede;
  logic       amostraAtiva;
  logic       disparo;
  logic       ackAceito;
  logic       limpaCont;

  logic [NUM_SENSORES-1:0] disparoVec;
  logic [NUM_SENSORES-1:0] atingidoVec;

  // Shared input mux and limit select
  always_comb begin
    amostra = '0;
    limiar  = 9'(LIMIAR_GERAL);
    case (idx)
      IDX_SC:    begin amostra = {1'b0, bus.sensTempSC}; limiar = 9'(LIMIAR_SC); end
      IDX_S1:    amostra = {1'b0, bus.sensTempS1};
      IDX_S2:    amostra = {1'b0, bus.sensTempS2};
      IDX_S3:    amostra = {1'b0, bus.sensTempS3};
      IDX_TUBSR: amostra = {1'b0, bus.sensTempTubSR};
      IDX_TUBSS: amostra = {1'b0, bus.sensTempTubSS};
      IDX_REA:   begin amostra = bus.sensTempRea; limiar = 9'(LIMIAR_REA); end
      default:   amostra = '0;
    endcase
  end

  assign excede = (amostra >= limiar);

  // ALARME keeps scanning regardless of habilita
  assign amostraAtiva = (estadoAtual == ALARME) ||
                        ((estadoAtual == VARRE) && bus.habilita);

  assign idxSeguinte = (idx == IDX_REA) ? IDX_SC : idx + 3'd1;

  assign disparo = |disparoVec;

  // Acknowledge uses the mask from before the edge; a same-edge trip wins
  assign ackAceito = (estadoAtual == ALARME) && bus.reconhece &&
                     (atingidoVec == '0) && !disparo;

  assign limpaCont = ((estadoAtual == VARRE) && !bus.habilita) ||
                     (ackAceito && !bus.habilita);

  for (genvar i = 0; i < NUM_SENSORES; i++) begin : g_cont
    contador_persistencia #(
      .PERSIST(PERSIST)
    ) u_cont (
      .clk     (clk),
      .rst     (rst),
      .limpa   (limpaCont),
      .enable  (amostraAtiva && (idx == 3'(i))),
      .exceed  (excede),
      .atingido(atingidoVec[i]),
      .disparo (disparoVec[i])
    );
  end

  always_comb begin
    proxEstado    = estadoAtual;
    proxIdx       = idx;
    proxAlarme    = alarme;
    proxOrigem    = origem;
    proxVarredura = amostraAtiva && (idx == IDX_REA);
    case (estadoAtual)
      OCIOSO: begin
        proxIdx = IDX_SC;
        if (bus.habilita) proxEstado = VARRE;
      end
      VARRE: begin
        if (!bus.habilita) begin
          proxEstado = OCIOSO;
          proxIdx    = IDX_SC;
        end else begin
          proxIdx = idxSeguinte;
          if (disparo) begin
            proxEstado = ALARME;
            proxAlarme = 1'b1;
            proxOrigem = idx;
          end
        end
      end
      ALARME: begin
        proxIdx = idxSeguinte;
        if (ackAceito) begin
          proxAlarme = 1'b0;
          proxOrigem = '0;
          if (bus.habilita) begin
            proxEstado = VARRE;
          end else begin
            proxEstado = OCIOSO;
            proxIdx    = IDX_SC;
          end
        end
      end
      default: begin
        proxEstado = OCIOSO;
        proxIdx    = IDX_SC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estadoAtual <= OCIOSO;
      idx         <= '0;
      alarme      <= 1'b0;
      origem      <= '0;
      varredura   <= 1'b0;
    end else begin
      estadoAtual <= proxEstado;
      idx         <= proxIdx;
      alarme      <= proxAlarme;
      origem      <= proxOrigem;
      varredura   <= proxVarredura;
    end
  end

  assign bus.alarmeSonoroTemperatura = alarme;
  assign bus.origemAlarme            = origem;
  assign bus.mascaraExcedido         = atingidoVec;
  assign bus.varreduraCompleta       = varredura;

endmodule

// File: tb/tb_sequenciador_alarme_temperatura.sv
module tb_sequenciador_alarme_temperatura;
  import pacote_temperatura::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   pulsos;

  always #5 clk = ~clk;

  sequenciador_alarme_temperatura_if bus ();

  sequenciador_alarme_temperatura #(
    .PERSIST(3),
    .LIMIAR_SC(50),
    .LIMIAR_GERAL(100),
    .LIMIAR_REA(300)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic todos20();
    bus.sensTempSC    = 8'd20;
    bus.sensTempS1    = 8'd20;
    bus.sensTempS2    = 8'd20;
    bus.sensTempS3    = 8'd20;
    bus.sensTempTubSR = 8'd20;
    bus.sensTempTubSS = 8'd20;
    bus.sensTempRea   = 9'd20;
  endtask

  // Reset with habilita=1 so the next tick is edge 0
  task automatic doReset();
    rst = 1'b1;
    bus.habilita  = 1'b1;
    bus.reconhece = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.habilita  = 1'b0;
    bus.reconhece = 1'b0;
    todos20();
    bus.sensTempRea = 9'd301;
    #1;
    chk("rst_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
    chk("rst_origem", 32'(bus.origemAlarme), 0);
    chk("rst_mask",   32'(bus.mascaraExcedido), 0);
    chk("rst_varr",   32'(bus.varreduraCompleta), 0);
    tick();
    tick();
    rst = 1'b0;

    // Reactor trip: samples on edges 7, 14, 21
    bus.habilita = 1'b1;
    tick(); // edge 0
    chk("rea_e0_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
    for (int e = 1; e <= 21; e++) begin
      tick();
      chk("rea_varr", 32'(bus.varreduraCompleta), ((e % 7) == 0) ? 1 : 0);
      if (e == 20) chk("rea_e20_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
    end
    chk("rea_alarme", 32'(bus.alarmeSonoroTemperatura), 1);
    chk("rea_origem", 32'(bus.origemAlarme), 6);
    chk("rea_mask",   32'(bus.mascaraExcedido), 32'h40);
    chk("rea_estado", 32'(dut.estadoAtual), 32'(ALARME));

    // Asynchronous reset while latched
    #2;
    rst = 1'b1;
    #1;
    chk("arst_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
    chk("arst_origem", 32'(bus.origemAlarme), 0);
    chk("arst_mask",   32'(bus.mascaraExcedido), 0);
    chk("arst_varr",   32'(bus.varreduraCompleta), 0);
    todos20();
    bus.sensTempSC = 8'd50;
    tick();
    chk("arst_hold_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
    rst = 1'b0;

    // Restart at idx 0; SC=50 (boundary, >=) trips on edge 15
    tick(); // edge 0
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 7)  chk("sc_restart_varr", 32'(bus.varreduraCompleta), 1);
      if (e == 14) chk("sc_e14_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
    end
    chk("sc_alarme", 32'(bus.alarmeSonoroTemperatura), 1);
    chk("sc_origem", 32'(bus.origemAlarme), 0);
    chk("sc_mask",   32'(bus.mascaraExcedido), 32'h01);

    // SC=49 never trips, S1 alternating 100/99 never trips, S2=120 trips at 17
    todos20();
    bus.sensTempSC = 8'd49;
    bus.sensTempS1 = 8'd100;
    bus.sensTempS2 = 8'd120;
    doReset();
    tick(); // edge 0
    for (int e = 1; e <= 28; e++) begin
      tick();
      if ((e % 7) == 0) bus.sensTempS1 = (((e / 7) % 2) == 1) ? 8'd99 : 8'd100;
      if (e == 16) chk("s2_e16_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
      if (e == 17) begin
        chk("s2_alarme", 32'(bus.alarmeSonoroTemperatura), 1);
        chk("s2_origem", 32'(bus.origemAlarme), 2);
        chk("s2_mask",   32'(bus.mascaraExcedido), 32'h04);
      end
    end
    chk("s1_sc_notrip_mask", 32'(bus.mascaraExcedido), 32'h04);

    // Acknowledge with S2 still hot is ignored
    bus.sensTempS1 = 8'd20;
    bus.reconhece  = 1'b1;
    tick(); // edge 29
    bus.reconhece = 1'b0;
    chk("ack_hot_alarme", 32'(bus.alarmeSonoroTemperatura), 1);
    bus.sensTempS2 = 8'd90;
    tick(); // edge 30
    tick(); // edge 31 samples S2
    chk("ack_cool_mask",   32'(bus.mascaraExcedido), 0);
    chk("ack_cool_alarme", 32'(bus.alarmeSonoroTemperatura), 1);
    bus.reconhece = 1'b1;
    tick(); // edge 32
    bus.reconhece = 1'b0;
    chk("ack_ok_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
    chk("ack_ok_origem", 32'(bus.origemAlarme), 0);
    chk("ack_ok_estado", 32'(dut.estadoAtual), 32'(VARRE));

    // First trip holds: S1 trips on 16, TubSS on 20
    todos20();
    bus.sensTempS1    = 8'd150;
    bus.sensTempTubSS = 8'd150;
    doReset();
    tick(); // edge 0
    for (int e = 1; e <= 21; e++) begin
      tick();
      if (e == 15) chk("ft_e15_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
      if (e == 16) begin
        chk("ft_e16_origem", 32'(bus.origemAlarme), 1);
        chk("ft_e16_mask",   32'(bus.mascaraExcedido), 32'h02);
      end
    end
    chk("ft_alarme", 32'(bus.alarmeSonoroTemperatura), 1);
    chk("ft_origem", 32'(bus.origemAlarme), 1);
    chk("ft_mask",   32'(bus.mascaraExcedido), 32'h22);

    // habilita=0 in VARRE: scan stops, counters clear
    todos20();
    bus.sensTempSC = 8'd60;
    doReset();
    tick(); // edge 0
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("dis_varr", 32'(bus.varreduraCompleta), (e == 7) ? 1 : 0);
    end
    bus.habilita = 1'b0;
    pulsos = 0;
    for (int e = 0; e < 11; e++) begin
      tick();
      if (bus.varreduraCompleta === 1'b1) pulsos++;
    end
    chk("dis_pulsos", 32'(pulsos), 0);
    chk("dis_estado", 32'(dut.estadoAtual), 32'(OCIOSO));
    chk("dis_mask",   32'(bus.mascaraExcedido), 0);
    bus.habilita = 1'b1;
    tick(); // restart edge 0
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (j == 1) chk("dis_clr_j1_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
      if (j == 7) chk("dis_j7_varr", 32'(bus.varreduraCompleta), 1);
      if (j == 8) chk("dis_clr_j8_alarme", 32'(bus.alarmeSonoroTemperatura), 0);
    end
    chk("dis_j15_alarme", 32'(bus.alarmeSonoroTemperatura), 1);
    chk("dis_j15_origem", 32'(bus.origemAlarme), 0);

    // habilita=0 in ALARME: scanning continues, alarm stays
    bus.habilita = 1'b0;
    pulsos = 0;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (bus.varreduraCompleta === 1'b1) pulsos++;
    end
    chk("alm_dis_pulsos", 32'(pulsos), 1);
    chk("alm_dis_alarme", 32'(bus.alarmeSonoroTemperatura), 1);
    chk("alm_dis_estado", 32'(dut.estadoAtual), 32'(ALARME));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
